// File: rtl/alu_rs_entry_if.sv
// Common data bus seen by reservation-station entries: one result broadcast
// per cycle, tagged with the ROB entry that produced it.
interface commonDataBus #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
);
  logic [WIDTH:0] result;
  logic [ROB:0]   robEntry;
  logic           validBroadcast;

  // Reservation-station entries only snoop the bus.
  modport rs (input result, input robEntry, input validBroadcast);
endinterface

// File: rtl/alu_rs_entry.sv
// alu_rs_entry: one slot of the ALU reservation station.
// Holds a dispatched op and its two operands, wakes operands from CDB
// broadcasts (also forwarding a matching broadcast combinationally), requests
// issue when both operands are available and frees itself when granted.
// Optional macro RS_EXEC_GATE_EN: when defined, the issue request also needs
// the execute flag latched at dispatch.
module alu_rs_entry #(
  parameter int WIDTH   = 31,
  parameter int ROB     = 2,
  parameter int C_WIDTH = 3
) (
  input  logic                clk,
  input  logic                clear,
  commonDataBus.rs            dataBus,
  input  logic                writeReq,
  input  logic signed [WIDTH:0] value1,
  input  logic signed [WIDTH:0] value2,
  input  logic                ready1,
  input  logic                ready2,
  input  logic [ROB:0]        rob1,
  input  logic [ROB:0]        rob2,
  input  logic [C_WIDTH:0]    ALUControl,
  input  logic [ROB:0]        robInstr,
  input  logic                execute,
  input  logic                selected,
  output logic                busy,
  output logic                selectReq,
  output logic signed [WIDTH:0] src1,
  output logic signed [WIDTH:0] src2,
  output logic [C_WIDTH:0]    instrInfo,
  output logic [ROB:0]        instrRob
);

  logic                 busy_q,   busy_d;
  logic                 ready1_q, ready1_d;
  logic                 ready2_q, ready2_d;
  logic signed [WIDTH:0] value1_q, value1_d;
  logic signed [WIDTH:0] value2_q, value2_d;
  logic [ROB:0]         rob1_q,   rob1_d;
  logic [ROB:0]         rob2_q,   rob2_d;
  logic [C_WIDTH:0]     ctrl_q,   ctrl_d;
  logic [ROB:0]         rob_instr_q, rob_instr_d;
  logic                 exec_q,   exec_d;

  logic match1, match2;   // live broadcast hits a stored, not-ready operand
  logic cap1, cap2;       // live broadcast hits an operand being dispatched
  logic eff1, eff2;

  // Broadcast matching, forwarding and the issue request.
  always_comb begin
    match1 = ~ready1_q & dataBus.validBroadcast & (dataBus.robEntry == rob1_q);
    match2 = ~ready2_q & dataBus.validBroadcast & (dataBus.robEntry == rob2_q);
    cap1   = ~ready1   & dataBus.validBroadcast & (dataBus.robEntry == rob1);
    cap2   = ~ready2   & dataBus.validBroadcast & (dataBus.robEntry == rob2);
    eff1   = ready1_q | match1;
    eff2   = ready2_q | match2;
    src1   = match1 ? dataBus.result : value1_q;
    src2   = match2 ? dataBus.result : value2_q;
`ifdef RS_EXEC_GATE_EN
    selectReq = busy_q & eff1 & eff2 & exec_q;
`else
    selectReq = busy_q & eff1 & eff2;
`endif
  end

`ifndef RS_EXEC_GATE_EN
  // The execute flag is kept for the gated build only.
  logic unused_exec;
  assign unused_exec = exec_q;
`endif

  assign busy      = busy_q;
  assign instrInfo = ctrl_q;
  assign instrRob  = rob_instr_q;

  // Next-state: dispatch (with same-edge capture) beats wakeup and select.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    busy_d      = busy_q;
    ready1_d    = ready1_q;
    ready2_d    = ready2_q;
    value1_d    = value1_q;
    value2_d    = value2_q;
    rob1_d      = rob1_q;
    rob2_d      = rob2_q;
    ctrl_d      = ctrl_q;
    rob_instr_d = rob_instr_q;
    exec_d      = exec_q;

    if (writeReq) begin
      busy_d      = 1'b1;
      ready1_d    = ready1 | cap1;
      ready2_d    = ready2 | cap2;
      value1_d    = cap1 ? dataBus.result : value1;
      value2_d    = cap2 ? dataBus.result : value2;
      rob1_d      = rob1;
      rob2_d      = rob2;
      ctrl_d      = ALUControl;
      rob_instr_d = robInstr;
      exec_d      = execute;
    end else if (busy_q) begin
      if (match1) begin
        ready1_d = 1'b1;
        value1_d = dataBus.result;
      end
      if (match2) begin
        ready2_d = 1'b1;
        value2_d = dataBus.result;
      end
      if (selected) busy_d = 1'b0;
    end
  end

  // State register with synchronous clear taking priority.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      busy_q      <= 1'b0;
      ready1_q    <= 1'b0;
      ready2_q    <= 1'b0;
      value1_q    <= '0;
      value2_q    <= '0;
      rob1_q      <= '0;
      rob2_q      <= '0;
      ctrl_q      <= '0;
      rob_instr_q <= '0;
      exec_q      <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      ready1_q    <= ready1_d;
      ready2_q    <= ready2_d;
      value1_q    <= value1_d;
      value2_q    <= value2_d;
      rob1_q      <= rob1_d;
      rob2_q      <= rob2_d;
      ctrl_q      <= ctrl_d;
      rob_instr_q <= rob_instr_d;
      exec_q      <= exec_d;
    end
  end

endmodule

// File: tb/tb_alu_rs_entry.sv
// Self-checking bench for alu_rs_entry: directed test-plan steps followed by
// randomized traffic, all compared against an operand-level reference model.
module tb_alu_rs_entry;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, write_req, exec_in, sel;
  logic [31:0] in_v [2];
  logic        in_r [2];
  logic [2:0]  in_t [2];
  logic [3:0]  ctrl_in;
  logic [2:0]  rob_in;

  logic        busy, select_req;
  logic signed [31:0] src1, src2;
  logic [3:0]  instr_info;
  logic [2:0]  instr_rob;

  commonDataBus #(.WIDTH(31), .ROB(2)) cdb ();

  alu_rs_entry dut (
    .clk(clk), .clear(clear), .dataBus(cdb), .writeReq(write_req),
    .value1(in_v[0]), .value2(in_v[1]), .ready1(in_r[0]), .ready2(in_r[1]),
    .rob1(in_t[0]), .rob2(in_t[1]), .ALUControl(ctrl_in), .robInstr(rob_in),
    .execute(exec_in), .selected(sel), .busy(busy), .selectReq(select_req),
    .src1(src1), .src2(src2), .instrInfo(instr_info), .instrRob(instr_rob)
  );

  // Reference model: the entry as a record of an op and two operand slots.
  bit          m_busy, m_exec;
  bit          m_rdy [2];
  logic [31:0] m_val [2];
  logic [2:0]  m_tag [2];
  logic [3:0]  m_ctrl;
  logic [2:0]  m_rob;

  int errors = 0;
  int checks = 0;

  function automatic bit hit(input bit rdy, input logic [2:0] tag);
    return !rdy && cdb.validBroadcast && cdb.robEntry == tag;
  endfunction

  function automatic logic [31:0] exp_src(input int i);
    return hit(m_rdy[i], m_tag[i]) ? cdb.result : m_val[i];
  endfunction

  function automatic bit exp_req();
    bit ok;
    ok = m_busy && (m_rdy[0] || hit(m_rdy[0], m_tag[0]))
                && (m_rdy[1] || hit(m_rdy[1], m_tag[1]));
`ifdef RS_EXEC_GATE_EN
    ok = ok && m_exec;
`endif
    return ok;
  endfunction

  function automatic bit gated_exp(input bit base);
`ifdef RS_EXEC_GATE_EN
    return 1'b0;
`else
    return base;
`endif
  endfunction

  task automatic model_edge();
    bit h [2];
    for (int i = 0; i < 2; i++) h[i] = hit(m_rdy[i], m_tag[i]);
    if (clear) begin
      m_busy = 0; m_exec = 0; m_ctrl = '0; m_rob = '0;
      for (int i = 0; i < 2; i++) begin m_rdy[i] = 0; m_val[i] = '0; m_tag[i] = '0; end
    end else if (write_req) begin
      m_busy = 1; m_exec = exec_in; m_ctrl = ctrl_in; m_rob = rob_in;
      for (int i = 0; i < 2; i++) begin
        bit c;
        c = hit(in_r[i], in_t[i]);
        m_rdy[i] = in_r[i] || c;
        m_val[i] = c ? cdb.result : in_v[i];
        m_tag[i] = in_t[i];
      end
    end else if (m_busy) begin
      for (int i = 0; i < 2; i++)
        if (h[i]) begin m_rdy[i] = 1; m_val[i] = cdb.result; end
      if (sel) m_busy = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("busy",      32'(busy),       32'(m_busy));
    check("selectReq", 32'(select_req), 32'(exp_req()));
    check("src1",      src1,            exp_src(0));
    check("src2",      src2,            exp_src(1));
    check("instrInfo", 32'(instr_info), 32'(m_ctrl));
    check("instrRob",  32'(instr_rob),  32'(m_rob));
  endtask

  // Compare settled outputs, take one edge, advance the model with it.
  task automatic tick();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_bus(input bit v, input logic [2:0] tag, input logic [31:0] res);
    cdb.validBroadcast = v; cdb.robEntry = tag; cdb.result = res;
  endtask

  task automatic dispatch(input logic [31:0] v1, input bit r1, input logic [2:0] t1,
                          input logic [31:0] v2, input bit r2, input logic [2:0] t2,
                          input logic [3:0] c, input logic [2:0] rb, input bit ex);
    write_req = 1; in_v[0] = v1; in_r[0] = r1; in_t[0] = t1;
    in_v[1] = v2; in_r[1] = r2; in_t[1] = t2; ctrl_in = c; rob_in = rb; exec_in = ex;
  endtask

  initial begin
    clear = 1; write_req = 0; sel = 0; exec_in = 0; ctrl_in = '0; rob_in = '0;
    for (int i = 0; i < 2; i++) begin in_v[i] = '0; in_r[i] = 0; in_t[i] = '0; end
    set_bus(0, '0, '0);
    m_busy = 1; m_exec = 1; m_ctrl = 4'hf; m_rob = 3'h7;
    for (int i = 0; i < 2; i++) begin m_rdy[i] = 1; m_val[i] = '1; m_tag[i] = '1; end
    @(posedge clk); model_edge(); #1;
    clear = 0;

    // Reset state.
    #1 check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(select_req), 32'd0);
    check("rst_src1", src1, 32'd0);
    check("rst_src2", src2, 32'd0);
    check("rst_info", 32'(instr_info), 32'd0);
    check("rst_rob", 32'(instr_rob), 32'd0);
    tick();

    // Both operands ready at dispatch: request one cycle later.
    dispatch(3, 1, 0, 7, 1, 0, 4'b1010, 5, 1); tick();
    write_req = 0;
    #1 check("tp1_busy", 32'(busy), 32'd1);
    check("tp1_src1", src1, 32'd3);
    check("tp1_src2", src2, 32'd7);
    check("tp1_info", 32'(instr_info), 32'b1010);
    check("tp1_rob", 32'(instr_rob), 32'd5);
    check("tp1_req", 32'(select_req), 32'd1);
    tick();

    // Grant frees the entry; a further grant while idle does nothing.
    sel = 1; tick();
    #1 check("sel_busy", 32'(busy), 32'd0);
    check("sel_req", 32'(select_req), 32'd0);
    tick();
    sel = 0;

    // Wakeup of operand 1 from the bus, forwarded in the same cycle.
    dispatch(0, 0, 4, 0, 0, 0, 4'b0110, 2, 1); tick();
    write_req = 0; set_bus(1, 4, 30);
    #1 check("wk_src1_fwd", src1, 32'd30);
    check("wk_busy", 32'(busy), 32'd1);
    check("wk_req0", 32'(select_req), 32'd0);
    tick();
    set_bus(0, 4, 0);
    #1 check("wk_src1_held", src1, 32'd30);
    set_bus(1, 2, 99); tick();          // wrong tag
    set_bus(0, 0, 55); tick();          // right tag, not valid
    set_bus(1, 0, 60);
    #1 check("wk_req1", 32'(select_req), 32'd1);
    check("wk_src2_fwd", src2, 32'd60);
    tick();
    set_bus(0, 0, 0);

    // Both operands wait on the same producer; execute flag clear.
    dispatch(0, 0, 5, 0, 0, 5, 4'b0010, 4, 0); tick();
    write_req = 0; set_bus(1, 5, 23);
    #1 check("dual_src1", src1, 32'd23);
    check("dual_src2", src2, 32'd23);
    check("dual_req", 32'(select_req), 32'(gated_exp(1'b1)));
    check("dual_rob", 32'(instr_rob), 32'd4);
    tick();
    set_bus(0, 0, 0);

    // Capture on the dispatch edge itself.
    dispatch(0, 0, 3, 11, 1, 0, 4'b0001, 6, 1); set_bus(1, 3, 9); tick();
    write_req = 0; set_bus(0, 0, 0);
    #1 check("cap_src1", src1, 32'd9);
    check("cap_req", 32'(select_req), 32'd1);
    tick();

    // Write beats a simultaneous grant; clear beats a write.
    sel = 1; dispatch(1, 1, 0, 2, 1, 0, 4'b0011, 1, 1); tick();
    sel = 0; write_req = 0;
    #1 check("coll_busy", 32'(busy), 32'd1);
    check("coll_info", 32'(instr_info), 32'b0011);
    clear = 1; write_req = 1; tick();
    clear = 0; write_req = 0;
    #1 check("clr_busy", 32'(busy), 32'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      clear     = ($urandom_range(0, 49) == 0);
      write_req = ($urandom_range(0, 3) == 0);
      sel       = ($urandom_range(0, 2) == 0);
      exec_in   = 1'($urandom_range(0, 1));
      ctrl_in   = 4'($urandom);
      rob_in    = 3'($urandom);
      for (int i = 0; i < 2; i++) begin
        in_v[i] = $urandom;
        in_r[i] = ($urandom_range(0, 2) == 0);
        in_t[i] = 3'($urandom_range(0, 3));
      end
      set_bus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
